svm_feat_packer: RTL and testbench
==================================

SVM_FEAT_PACKER -- requirements
Module: svm_feat_packer

Interface
REQ-001 Parameter N_FEAT, 7, number of features per classification vector.
REQ-002 Parameter RAW_W, 8, raw sensor sample width.
REQ-003 Parameter FEAT_W, 5, quantized feature width; output vector width VEC_W = N_FEAT*FEAT_W = 35.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 Port in_valid  input  1  raw sample present.
REQ-007 Port in_ready  output  1  packer accepts sample this cycle.
REQ-008 Port in_data  input  RAW_W  raw unsigned sample.
REQ-009 Port in_sof  input  1  sample is first of a frame; used only under the configuration macro.
REQ-010 Port out_valid  output  1  packed vector available to the downstream SVM classifier.
REQ-011 Port out_ready  input  1  classifier consumes vector.
REQ-012 Port out_vec  output  VEC_W  packed features; slot k occupies bits [k*FEAT_W+FEAT_W-1 : k*FEAT_W].
REQ-013 Port err_cnt  output  8  count of aborted partial frames.

Function
REQ-014 A sample SHALL be accepted exactly when in_valid && in_ready.
REQ-015 Quantization SHALL be truncation: q = in_data[RAW_W-1 : RAW_W-FEAT_W] (0x00-0x07 -> 0, 0xF8-0xFF -> 31), implemented in a pure combinational path.
REQ-016 Slot index idx (0..N_FEAT-1) SHALL be the collection state: each accept writes q into slot idx, then increments idx; accept at idx = N_FEAT-1 wraps idx to 0.
REQ-017 On accept at idx = N_FEAT-1, the complete vector (including this sample) SHALL load the output register; out_valid SHALL rise on the next edge (latency 1 cycle after last accept).
REQ-018 The output register has two states, EMPTY (out_valid=0) and FULL (out_valid=1); FULL->EMPTY on out_ready without a load; EMPTY->FULL on load; FULL with out_ready and a load SHALL stay FULL with the new vector (no bubble).
REQ-019 in_ready SHALL be combinational: low only when idx = N_FEAT-1 && out_valid && !out_ready; high otherwise, including during reset release.
REQ-020 out_vec SHALL remain stable while out_valid && !out_ready.
REQ-021 Slots 0..N_FEAT-2 SHALL keep accepting while the output register is FULL; only the last sample stalls.
REQ-022 Collection registers not yet overwritten in a new frame are don't-care; out_vec reflects only the loaded frame.

Reset
REQ-023 rst_n low SHALL immediately clear idx to 0, out_valid to 0, out_vec to 0, collection slots to 0, err_cnt to 0.
REQ-024 Reset mid-frame SHALL discard the partial frame; the first accept after release writes slot 0.

Configuration
REQ-025 Macro SVM_FEAT_PACKER_SOF_RESYNC_EN: when defined, an accepted sample with in_sof=1 and idx != 0 SHALL discard the partial frame, store the sample in slot 0, set idx to 1, and increment err_cnt, saturating at 255; in_sof at idx = 0 is normal.
REQ-026 When undefined, in_sof SHALL be ignored and err_cnt SHALL be constant 0.

Structure
REQ-027 Package svm_feat_pkg SHALL hold N_FEAT, RAW_W, FEAT_W, VEC_W defaults and the output-register state enum {EMPTY, FULL}.
REQ-028 Sub-module svm_feat_quant (combinational RAW_W -> FEAT_W truncation) SHALL be instantiated once.
REQ-029 Target size 120-400 RTL lines.

Verification
REQ-030 Reset, out_ready=1, feed 0x08,0x10,0x18,0x20,0x28,0x30,0x38 back-to-back -> out_valid one cycle after 7th accept, out_vec slots 0..6 = 1..7.
REQ-031 out_ready=0, feed 14 samples continuously -> first vector held stable, in_ready low on 14th sample; raise out_ready -> 14th accepted same cycle, second vector valid next cycle.
REQ-032 Samples 0xFF and 0x07 -> slots read 31 and 0.
REQ-033 out_valid=1, out_ready=1 in the same cycle as 7th accept -> out_valid stays 1, out_vec updates to new frame, no idle cycle.
REQ-034 Macro defined: in_sof=1 at idx=3 -> err_cnt=1, next vector built from that sample onward; macro undefined, same stimulus -> err_cnt=0, frame packed unchanged.
REQ-035 Assert rst_n low at idx=4 -> out_valid, out_vec, err_cnt 0 without clock edge; after release 7 samples form a full vector starting at slot 0.

Source files
------------

// File: rtl/svm_feat_pkg.sv
// ============================================================================
// svm_feat_pkg: shared defaults and output-register state for the feature packer
// Revision: 1.0
// ============================================================================
`default_nettype none

package svm_feat_pkg;

  localparam int N_FEAT = 7;
  localparam int RAW_W  = 8;
  localparam int FEAT_W = 5;
  localparam int VEC_W  = N_FEAT * FEAT_W;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

`default_nettype wire

// File: rtl/svm_feat_quant.sv
// ============================================================================
// svm_feat_quant: truncating quantizer, keeps the FEAT_W most significant bits
// Revision: 1.0
// ============================================================================
`default_nettype none

module svm_feat_quant
  import svm_feat_pkg::*;
#(
  parameter int RAW_W  = svm_feat_pkg::RAW_W,
  parameter int FEAT_W = svm_feat_pkg::FEAT_W
) (
  input  logic [RAW_W-1:0]  raw,
  output logic [FEAT_W-1:0] q
);

  assign q = raw[RAW_W-1 -: FEAT_W];

  generate
    if (RAW_W > FEAT_W) begin : g_drop_lsb
      logic [RAW_W-FEAT_W-1:0] unused_lsb;
      assign unused_lsb = raw[RAW_W-FEAT_W-1:0];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/svm_feat_packer.sv
// ============================================================================
// svm_feat_packer: packs quantized raw samples into N_FEAT-slot SVM vectors.
// Optional SOF resync via `SVM_FEAT_PACKER_SOF_RESYNC_EN. Revision: 1.0
// ============================================================================
`default_nettype none

module svm_feat_packer
  import svm_feat_pkg::*;
#(
  parameter int N_FEAT = svm_feat_pkg::N_FEAT,
  parameter int RAW_W  = svm_feat_pkg::RAW_W,
  parameter int FEAT_W = svm_feat_pkg::FEAT_W,
  parameter int VEC_W  = N_FEAT * FEAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RAW_W-1:0] in_data,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] out_vec,
  output logic [7:0]       err_cnt
);

  localparam int              IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_FEAT - 1);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [FEAT_W-1:0] slot_q [N_FEAT];
  logic [FEAT_W-1:0] slot_d [N_FEAT];
  logic [VEC_W-1:0]  vec_q, vec_d;
  out_state_e        state_q, state_d;
  logic [FEAT_W-1:0] q;
  logic              accept;
  logic              load;
  logic              resync;

  svm_feat_quant #(
    .RAW_W  (RAW_W),
    .FEAT_W (FEAT_W)
  ) u_quant (
    .raw (in_data),
    .q   (q)
  );

  // Only the frame-closing sample must wait for the output register.
  assign in_ready = !((idx_q == LAST) && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign load     = accept && !resync && (idx_q == LAST);

`ifdef SVM_FEAT_PACKER_SOF_RESYNC_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  assign resync  = accept && in_sof && (idx_q != '0);
  assign err_cnt = err_cnt_q;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (resync && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end
`else
  logic unused_sof;

  assign unused_sof = in_sof;
  assign resync     = 1'b0;
  assign err_cnt    = 8'd0;
`endif

  always_comb begin
    idx_d  = idx_q;
    slot_d = slot_q;
    if (resync) begin
      slot_d[0] = q;
      idx_d     = IDX_W'(1);
    end else if (accept) begin
      for (int k = 0; k < N_FEAT; k++) begin
        if (idx_q == IDX_W'(k)) begin
          slot_d[k] = q;
        end
      end
      idx_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // The last slot comes straight from the quantizer so the vector loads on the closing accept.
  always_comb begin
    vec_d = vec_q;
    if (load) begin
      for (int k = 0; k < N_FEAT; k++) begin
        vec_d[k*FEAT_W +: FEAT_W] = (k == N_FEAT - 1) ? q : slot_q[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (out_ready && !load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == FULL);
    out_vec   = vec_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      vec_q <= '0;
      for (int k = 0; k < N_FEAT; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      idx_q  <= idx_d;
      vec_q  <= vec_d;
      slot_q <= slot_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_svm_feat_packer.sv
// ============================================================================
// tb_svm_feat_packer: directed self-checking bench for svm_feat_packer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_svm_feat_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_sof;
  logic        out_valid;
  logic        out_ready;
  logic [34:0] out_vec;
  logic [7:0]  err_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  svm_feat_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .err_cnt   (err_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] pack7(input logic [4:0] s0, input logic [4:0] s1,
                                        input logic [4:0] s2, input logic [4:0] s3,
                                        input logic [4:0] s4, input logic [4:0] s5,
                                        input logic [4:0] s6);
    return {s6, s5, s4, s3, s2, s1, s0};
  endfunction

  // Present one sample and hold it until accepted on a rising edge.
  task automatic push(input logic [7:0] d, input logic sof);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check("push_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  logic [7:0] f1 [7] = '{8'h08, 8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38};
  logic [7:0] fa [7] = '{8'h80, 8'h88, 8'h90, 8'h98, 8'hA0, 8'hA8, 8'hB0};
  logic [7:0] fb [7] = '{8'hFF, 8'h07, 8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h9F};
  logic [7:0] fd [7] = '{8'hF8, 8'hF0, 8'hE8, 8'hE0, 8'hD8, 8'hD0, 8'hC8};
  logic [7:0] fe [10] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70,
                          8'h78, 8'h88, 8'h98};
  logic [7:0] ff [7] = '{8'h18, 8'h28, 8'h38, 8'h48, 8'h58, 8'h68, 8'h78};

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_sof    = 1'b0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_vec", {29'd0, out_vec}, 64'd0);
    check("rst_err_cnt", {56'd0, err_cnt}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic ramp frame, consumer always ready
    for (int i = 0; i < 7; i++) begin
      push(f1[i], 1'b0);
      if (i == 5) check("ramp_valid_early", {63'd0, out_valid}, 64'd0);
    end
    check("ramp_valid", {63'd0, out_valid}, 64'd1);
    check("ramp_vec", {29'd0, out_vec}, {29'd0, pack7(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7)});
    @(posedge clk);
    #1;
    check("ramp_drain", {63'd0, out_valid}, 64'd0);

    // Backpressure: 14 samples with consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) push(fa[i], 1'b0);
    check("bp_valid_a", {63'd0, out_valid}, 64'd1);
    for (int i = 0; i < 6; i++) push(fb[i], 1'b0);
    check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
    check("bp_hold_vec", {29'd0, out_vec},
          {29'd0, pack7(5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22)});
    in_valid = 1'b1;
    in_data  = fb[6];
    @(negedge clk);
    check("bp_stall_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    check("bp_stall_vec", {29'd0, out_vec},
          {29'd0, pack7(5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22)});
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_valid_b", {63'd0, out_valid}, 64'd1);
    check("bp_vec_b", {29'd0, out_vec},
          {29'd0, pack7(5'd31, 5'd0, 5'd11, 5'd20, 5'd7, 5'd24, 5'd19)});
    check("quant_ff", {59'd0, out_vec[4:0]}, 64'd31);
    check("quant_07", {59'd0, out_vec[9:5]}, 64'd0);
    @(posedge clk);
    #1;
    check("bp_drain", {63'd0, out_valid}, 64'd0);

    // Load and consume in the same cycle: no bubble
    for (int i = 0; i < 7; i++) push(f1[i], 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(fd[i], 1'b0);
    check("nb_hold_vec", {29'd0, out_vec}, {29'd0, pack7(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7)});
    out_ready = 1'b1;
    push(fd[6], 1'b0);
    check("nb_valid", {63'd0, out_valid}, 64'd1);
    check("nb_vec", {29'd0, out_vec},
          {29'd0, pack7(5'd31, 5'd30, 5'd29, 5'd28, 5'd27, 5'd26, 5'd25)});
    @(posedge clk);
    #1;
    check("nb_drain", {63'd0, out_valid}, 64'd0);

    // Start-of-frame marker in the middle of a frame
`ifdef SVM_FEAT_PACKER_SOF_RESYNC_EN
    for (int i = 0; i < 10; i++) push(fe[i], (i == 3));
    check("sof_err_cnt", {56'd0, err_cnt}, 64'd1);
    check("sof_vec", {29'd0, out_vec},
          {29'd0, pack7(5'd8, 5'd10, 5'd12, 5'd14, 5'd15, 5'd17, 5'd19)});
`else
    for (int i = 0; i < 7; i++) push(fe[i], (i == 3));
    check("sof_err_cnt", {56'd0, err_cnt}, 64'd0);
    check("sof_vec", {29'd0, out_vec},
          {29'd0, pack7(5'd2, 5'd4, 5'd6, 5'd8, 5'd10, 5'd12, 5'd14)});
`endif
    check("sof_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a frame
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) push(fa[i], 1'b0);
    for (int i = 0; i < 4; i++) push(fa[i], 1'b0);
    check("mid_valid_pre", {63'd0, out_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_vec", {29'd0, out_vec}, 64'd0);
    check("mid_rst_err", {56'd0, err_cnt}, 64'd0);
    check("mid_rst_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) push(ff[i], 1'b0);
    check("post_rst_valid", {63'd0, out_valid}, 64'd1);
    check("post_rst_vec", {29'd0, out_vec},
          {29'd0, pack7(5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd13, 5'd15)});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
